// File: rtl/cdb_arbiter_if.sv
// Request-side handshake and CDB broadcast bus for cdb_arbiter.
// The master drives requests and back-pressure; the slave (the arbiter) grants and broadcasts.
interface cdb_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_PORTS   = 2,
  parameter int ROB_ID_BITS = 6,
  parameter int DATA_W      = 32
);
  logic                             flush;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ROB_ID_BITS-1:0]   req_rob_id;
  logic [NUM_REQ*5-1:0]             req_rd_addr;
  logic [NUM_REQ*DATA_W-1:0]        req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             cdb_stall;
  logic [NUM_PORTS-1:0]             cdb_valid;
  logic [NUM_PORTS*ROB_ID_BITS-1:0] cdb_rob_id;
  logic [NUM_PORTS*5-1:0]           cdb_rd_addr;
  logic [NUM_PORTS*DATA_W-1:0]      cdb_data;

  modport master (
    output flush, req_valid, req_rob_id, req_rd_addr, req_data, cdb_stall,
    input  req_ready, cdb_valid, cdb_rob_id, cdb_rd_addr, cdb_data
  );

  modport slave (
    input  flush, req_valid, req_rob_id, req_rd_addr, req_data, cdb_stall,
    output req_ready, cdb_valid, cdb_rob_id, cdb_rd_addr, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing NUM_PORTS registered CDB broadcast ports among NUM_REQ requesters.
// Define CDB_PERF_CNT_EN to add saturating conflict/stall performance counters.
module cdb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_PORTS   = 2,
  parameter int ROB_ID_BITS = 6,
  parameter int DATA_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]  perf_conflict_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]             cdb_valid_q, cdb_valid_d;
  logic [NUM_PORTS*ROB_ID_BITS-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [NUM_PORTS*5-1:0]           cdb_rd_addr_q, cdb_rd_addr_d;
  logic [NUM_PORTS*DATA_W-1:0]      cdb_data_q, cdb_data_d;

  logic [ROB_ID_BITS-1:0] req_rob_id_a  [NUM_REQ];
  logic [4:0]             req_rd_addr_a [NUM_REQ];
  logic [DATA_W-1:0]      req_data_a    [NUM_REQ];

  logic                   grant_en;
  logic [2*NUM_REQ-1:0]   valid_dbl, grant_dbl;
  logic [NUM_REQ-1:0]     valid_rot, grant_rot, grant;
  logic [NUM_PORTS-1:0]   port_vld;
  logic [PTR_W-1:0]       port_sel [NUM_PORTS];
  logic [PTR_W-1:0]       last_sel;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rob_id_a[i]  = bus.req_rob_id[i*ROB_ID_BITS +: ROB_ID_BITS];
      req_rd_addr_a[i] = bus.req_rd_addr[i*5 +: 5];
      req_data_a[i]    = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Rotate requests so scan position k is requester (rr_ptr + k) mod NUM_REQ; grants rotate back.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int n;
    int s;
    grant_en  = rst_n && !bus.cdb_stall && !bus.flush;
    valid_dbl = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    valid_rot = valid_dbl[NUM_REQ-1:0];
    grant_rot = '0;
    port_vld  = '0;
    last_sel  = rr_ptr_q;
    n         = 0;
    s         = 0;
    for (int p = 0; p < NUM_PORTS; p++) port_sel[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_en && valid_rot[k] && n < NUM_PORTS) begin
        grant_rot[k] = 1'b1;
        s = int'(rr_ptr_q) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (n == p) begin
            port_vld[p] = 1'b1;
            port_sel[p] = PTR_W'(s);
          end
        end
        last_sel = PTR_W'(s);
        n = n + 1;
      end
    end
    grant_dbl = {grant_rot, grant_rot} << rr_ptr_q;
    grant     = grant_dbl[2*NUM_REQ-1:NUM_REQ];
  end

  assign bus.req_ready = grant;

  // Flush wins over stall; stall holds every output register and the pointer.
  always_comb begin
    int t;
    cdb_valid_d   = cdb_valid_q;
    cdb_rob_id_d  = cdb_rob_id_q;
    cdb_rd_addr_d = cdb_rd_addr_q;
    cdb_data_d    = cdb_data_q;
    rr_ptr_d      = rr_ptr_q;
    t             = int'(last_sel) + 1;
    if (t >= NUM_REQ) t = 0;
    if (bus.flush) begin
      cdb_valid_d = '0;
    end else if (!bus.cdb_stall) begin
      cdb_valid_d = port_vld;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cdb_rob_id_d[p*ROB_ID_BITS +: ROB_ID_BITS] =
          port_vld[p] ? req_rob_id_a[port_sel[p]] : '0;
        cdb_rd_addr_d[p*5 +: 5]       = port_vld[p] ? req_rd_addr_a[port_sel[p]] : '0;
        cdb_data_d[p*DATA_W +: DATA_W] = port_vld[p] ? req_data_a[port_sel[p]] : '0;
      end
      if (|grant) rr_ptr_d = PTR_W'(t);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      cdb_valid_q   <= '0;
      cdb_rob_id_q  <= '0;
      cdb_rd_addr_q <= '0;
      cdb_data_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_id_q  <= cdb_rob_id_d;
      cdb_rd_addr_q <= cdb_rd_addr_d;
      cdb_data_q    <= cdb_data_d;
    end
  end

  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_id  = cdb_rob_id_q;
  assign bus.cdb_rd_addr = cdb_rd_addr_q;
  assign bus.cdb_data    = cdb_data_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_stall_d    = perf_stall_q;
    if (!bus.cdb_stall && !bus.flush && ($countones(bus.req_valid) > NUM_PORTS) &&
        (perf_conflict_q != 32'hFFFF_FFFF))
      perf_conflict_d = perf_conflict_q + 32'd1;
    if (bus.cdb_stall && (|cdb_valid_q) && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_stall_cnt    = perf_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_REQ=4, NUM_PORTS=2, ROB_ID_BITS=6, DATA_W=32).
// Covers reset, fair share, sparse request, stall, flush, x0 destination and optional perf counters.
module tb_cdb_arbiter;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter_if #(.NUM_REQ(4), .NUM_PORTS(2), .ROB_ID_BITS(6), .DATA_W(32)) bus_if ();

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(4), .NUM_PORTS(2), .ROB_ID_BITS(6), .DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus_if)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] rob,
                         input logic [4:0] rd, input logic [31:0] data);
    bus_if.req_valid[i]          = v;
    bus_if.req_rob_id[i*6 +: 6]  = rob;
    bus_if.req_rd_addr[i*5 +: 5] = rd;
    bus_if.req_data[i*32 +: 32]  = data;
  endtask

  // Default requester i: rob_id 10+i, rd i+1, data A000_000i.
  task automatic all_default(input logic v);
    for (int i = 0; i < 4; i++)
      set_req(i, v, 6'(10 + i), 5'(i + 1), 32'hA000_0000 + 32'(i));
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.cdb_stall = 1'b0;
    all_default(1'b1);
    #1;
    check("reset_valid", 64'(bus_if.cdb_valid), 64'h0);
    check("reset_ready", 64'(bus_if.req_ready), 64'h0);
    check("reset_rob",   64'(bus_if.cdb_rob_id), 64'h0);
    #12 rst_n = 1'b1;
    #1;

    // Fair share: {0,1} then {2,3}.
    check("fair_ready1", 64'(bus_if.req_ready), 64'b0011);
    step();
    check("fair_valid1", 64'(bus_if.cdb_valid), 64'b11);
    check("fair_rob1",   64'(bus_if.cdb_rob_id), 64'({6'd11, 6'd10}));
    check("fair_rd1",    64'(bus_if.cdb_rd_addr), 64'({5'd2, 5'd1}));
    check("fair_data1",  64'(bus_if.cdb_data), {32'hA000_0001, 32'hA000_0000});
    check("fair_ready2", 64'(bus_if.req_ready), 64'b1100);
    step();
    check("fair_valid2", 64'(bus_if.cdb_valid), 64'b11);
    check("fair_rob2",   64'(bus_if.cdb_rob_id), 64'({6'd13, 6'd12}));
    check("fair_data2",  64'(bus_if.cdb_data), {32'hA000_0003, 32'hA000_0002});

    // Sparse: only req3, lands on port0.
    all_default(1'b0);
    set_req(3, 1'b1, 6'd5, 5'd7, 32'hDEAD_BEEF);
    #1;
    check("sparse_ready", 64'(bus_if.req_ready), 64'b1000);
    step();
    check("sparse_valid", 64'(bus_if.cdb_valid), 64'b01);
    check("sparse_rob",   64'(bus_if.cdb_rob_id[5:0]), 64'd5);
    check("sparse_rd",    64'(bus_if.cdb_rd_addr[4:0]), 64'd7);
    check("sparse_data",  64'(bus_if.cdb_data[31:0]), 64'hDEAD_BEEF);
    all_default(1'b1);
    #1;
    check("sparse_ptr0", 64'(bus_if.req_ready), 64'b0011);
    step();
    check("pre_stall_rob", 64'(bus_if.cdb_rob_id), 64'({6'd11, 6'd10}));

    // Stall for 3 cycles: outputs frozen, no grants, pointer held at 2.
    bus_if.cdb_stall = 1'b1;
    #1;
    check("stall_ready0", 64'(bus_if.req_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_valid", 64'(bus_if.cdb_valid), 64'b11);
      check("stall_rob",   64'(bus_if.cdb_rob_id), 64'({6'd11, 6'd10}));
      check("stall_data",  64'(bus_if.cdb_data), {32'hA000_0001, 32'hA000_0000});
      check("stall_ready", 64'(bus_if.req_ready), 64'h0);
    end
    bus_if.cdb_stall = 1'b0;
    #1;
    check("unstall_ready", 64'(bus_if.req_ready), 64'b1100);
    step();
    check("unstall_rob", 64'(bus_if.cdb_rob_id), 64'({6'd13, 6'd12}));

    // Only req1 valid with rd=x0: still broadcast; pointer moves to 2.
    all_default(1'b0);
    set_req(1, 1'b1, 6'd11, 5'd0, 32'hA000_0001);
    #1;
    check("x0_ready", 64'(bus_if.req_ready), 64'b0010);
    step();
    check("x0_valid", 64'(bus_if.cdb_valid), 64'b01);
    check("x0_rob",   64'(bus_if.cdb_rob_id[5:0]), 64'd11);
    check("x0_rd",    64'(bus_if.cdb_rd_addr[4:0]), 64'd0);

    // Flush over stall with all valid: drop outputs, no grants, pointer held.
    all_default(1'b1);
    bus_if.cdb_stall = 1'b1;
    bus_if.flush     = 1'b1;
    #1;
    check("flush_ready", 64'(bus_if.req_ready), 64'h0);
    step();
    check("flush_valid", 64'(bus_if.cdb_valid), 64'b00);
    bus_if.cdb_stall = 1'b0;
    bus_if.flush     = 1'b0;
    #1;
    check("flush_ptr", 64'(bus_if.req_ready), 64'b1100);

    // Async reset mid-broadcast with pointer at 2.
    step();
    check("prerst_rob", 64'(bus_if.cdb_rob_id), 64'({6'd13, 6'd12}));
    step();
    check("prerst_valid", 64'(bus_if.cdb_valid), 64'b11);
    check("prerst_ready", 64'(bus_if.req_ready), 64'b1100);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", 64'(bus_if.cdb_valid), 64'b00);
    check("async_ready", 64'(bus_if.req_ready), 64'h0);
    check("async_data",  64'(bus_if.cdb_data), 64'h0);
    #1 rst_n = 1'b1;
    #1;
    check("rst_ptr0", 64'(bus_if.req_ready), 64'b0011);

`ifdef CDB_PERF_CNT_EN
    repeat (10) step();
    check("perf_conflict10", 64'(perf_conflict_cnt), 64'd10);
    check("perf_stall0",     64'(perf_stall_cnt), 64'd0);
    bus_if.cdb_stall = 1'b1;
    step();
    step();
    check("perf_stall2",    64'(perf_stall_cnt), 64'd2);
    check("perf_conflict_hold", 64'(perf_conflict_cnt), 64'd10);
    bus_if.cdb_stall = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
